// File: rtl/hex_display_scan.sv
// hex_display_scan: time-multiplexed driver for a bank of 7-segment displays.
//
// Captures a 4*DIGITS-bit word (plus per-digit decimal points) into shadow
// registers on LOAD, then lights one digit at a time for SCAN_DIV cycles with
// an optional GUARD-cycle dark interval between digits to suppress ghosting.
//
// Ports:
//   CLK       in   clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   BIN       in   value to show; nibble i drives digit i (digit 0 rightmost)
//   DP        in   decimal point request per digit
//   LOAD      in   capture BIN/DP into the shadow registers
//   BLANK_LZ  in   leading-zero blanking enable (live)
//   SEG       out  segments {G,F,E,D,C,B,A}, registered
//   DP_OUT    out  decimal point segment, registered
//   AN        out  one-hot digit enable, registered
//   FRAME     out  one-cycle pulse at the start of each frame after the first
module hex_display_scan #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned GUARD          = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   BIN,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  LOAD,
    input  logic                  BLANK_LZ,
    output logic [6:0]            SEG,
    output logic                  DP_OUT,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CntMax = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DIGITS - 1);
    localparam logic [CntW-1:0]   ShowLast  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0]   GuardLast = CntW'((GUARD > 0) ? GUARD - 1 : 0);

    // Inactive levels of the pins, used for reset and for dark cycles.
    localparam logic [6:0]        SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DpOff  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AnOff  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef enum logic {StShow, StGuard} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    // Set at the first wrap to digit 0; keeps FRAME quiet for the first frame.
    logic                started_q, started_d;

    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   dp_q;

    logic [6:0]          seg_d;
    logic                dp_out_d;
    logic [DIGITS-1:0]   an_d;
    logic                frame_d;

    // Active-high {G..A} pattern for a hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Shadow registers: only LOAD touches them, never the scan.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_q <= '0;
            dp_q   <= '0;
        end else if (LOAD) begin
            data_q <= BIN;
            dp_q   <= DP;
        end
    end

    // Scan state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StShow;
            cnt_q     <= '0;
            idx_q     <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            started_q <= started_d;
        end
    end

    // Next-state logic.
    always_comb begin
        logic advance;
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        idx_d     = idx_q;
        started_d = started_q;
        advance   = 1'b0;

        unique case (state_q)
            StShow: begin
                if (cnt_q == ShowLast) begin
                    cnt_d = '0;
                    if (GUARD == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = StGuard;
                    end
                end
            end
            StGuard: begin
                if (cnt_q == GuardLast) begin
                    cnt_d   = '0;
                    state_d = StShow;
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = StShow;
                cnt_d   = '0;
            end
        endcase

        if (advance) begin
            if (idx_q == IdxLast) begin
                idx_d     = '0;
                started_d = 1'b1;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end
    end

    // Output decode, registered below for one cycle of latency.
    always_comb begin
        logic [3:0]        nib;
        logic              dp_sel;
        logic [DIGITS-1:0] an_hot;
        logic              blank;
        logic              hi_zero;
        logic              show;
        logic [6:0]        seg_on;

        nib     = 4'h0;
        dp_sel  = 1'b0;
        an_hot  = '0;
        blank   = 1'b0;
        hi_zero = 1'b1;
        show    = (state_q == StShow);

        // Walk from the most significant digit down so hi_zero means
        // "this nibble and every nibble above it are zero".
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            hi_zero = hi_zero & (data_q[4*i +: 4] == 4'h0);
            if (idx_q == IdxW'(i)) begin
                nib       = data_q[4*i +: 4];
                dp_sel    = dp_q[i];
                an_hot[i] = 1'b1;
                blank     = BLANK_LZ & hi_zero & (i != 0);
            end
        end

        seg_on   = (show && !blank) ? decode(nib) : 7'h00;
        seg_d    = seg_on ^ {7{SEG_ACTIVE_LOW}};
        dp_out_d = (show & dp_sel) ^ SEG_ACTIVE_LOW;
        an_d     = (show ? an_hot : {DIGITS{1'b0}}) ^ {DIGITS{AN_ACTIVE_LOW}};
        frame_d  = show && (idx_q == '0) && (cnt_q == '0) && started_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SEG    <= SegOff;
            DP_OUT <= DpOff;
            AN     <= AnOff;
            FRAME  <= 1'b0;
        end else begin
            SEG    <= seg_d;
            DP_OUT <= dp_out_d;
            AN     <= an_d;
            FRAME  <= frame_d;
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with DIGITS=4, SCAN_DIV=4, GUARD=1,
// both polarities active-low. Frame period is 20 cycles.
module tb_hex_display_scan;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] BIN = '0;
    logic [3:0]  DP = '0;
    logic        LOAD = 1'b0;
    logic        BLANK_LZ = 1'b0;
    logic [6:0]  SEG;
    logic        DP_OUT;
    logic [3:0]  AN;
    logic        FRAME;

    int n_cmp = 0;
    int n_err = 0;
    int e = 0;

    hex_display_scan #(
        .DIGITS        (4),
        .SCAN_DIV      (4),
        .GUARD         (1),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .BIN     (BIN),
        .DP      (DP),
        .LOAD    (LOAD),
        .BLANK_LZ(BLANK_LZ),
        .SEG     (SEG),
        .DP_OUT  (DP_OUT),
        .AN      (AN),
        .FRAME   (FRAME)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        e++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, " seg"}, {1'b0, SEG}, 8'h7F);
        chk({tag, " dp"}, {7'b0, DP_OUT}, 8'h01);
        chk({tag, " an"}, {4'b0, AN}, 8'h0F);
        chk({tag, " frame"}, {7'b0, FRAME}, 8'h00);
    endtask

    // Expected pins at edge number ee: segs holds the active-low SEG value of
    // digits {3,2,1,0}; dpm is the latched DP mask.
    task automatic chk_scan(input int ee, input logic [27:0] segs, input logic [3:0] dpm);
        int pos, d, r;
        logic [6:0] s;
        logic [3:0] a;
        logic dpo, fr;
        pos = (ee - 1) % 20;
        d   = pos / 5;
        r   = pos % 5;
        if (r == 4) begin
            s   = 7'h7F;
            a   = 4'hF;
            dpo = 1'b1;
        end else begin
            s   = segs[d*7 +: 7];
            a   = 4'hF & ~(4'b0001 << d);
            dpo = ~dpm[d];
        end
        fr = (pos == 0) && (ee > 1);
        chk($sformatf("e%0d seg", ee), {1'b0, SEG}, {1'b0, s});
        chk($sformatf("e%0d an", ee), {4'b0, AN}, {4'b0, a});
        chk($sformatf("e%0d dp", ee), {7'b0, DP_OUT}, {7'b0, dpo});
        chk($sformatf("e%0d frame", ee), {7'b0, FRAME}, {7'b0, fr});
    endtask

    initial begin
        // Reset held with random data and LOAD high.
        LOAD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            BIN = 16'($urandom);
            DP  = 4'($urandom);
            tick();
            chk_off($sformatf("rst%0d", i));
        end

        // Release and load 12AF; edge 1 still shows the cleared shadow.
        RST_N = 1'b1;
        BIN   = 16'h12AF;
        DP    = 4'h0;
        e     = 0;
        tick();
        chk_scan(e, {7'h79, 7'h24, 7'h08, 7'h40}, 4'h0);
        LOAD = 1'b0;
        while (e < 41) begin
            tick();
            chk_scan(e, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0);
        end

        // Asynchronous reset between edges while digit 0 is lit with FRAME high.
        #3;
        RST_N = 1'b0;
        #1;
        chk_off("async");
        tick();

        // Leading-zero blanking with 0030.
        RST_N    = 1'b1;
        LOAD     = 1'b1;
        BIN      = 16'h0030;
        BLANK_LZ = 1'b1;
        DP       = 4'h0;
        e        = 0;
        tick();
        chk_scan(e, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'h0);
        LOAD = 1'b0;
        while (e < 20) begin
            tick();
            chk_scan(e, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'h0);
        end

        // All-zero value with a decimal point on blanked digit 2.
        LOAD = 1'b1;
        BIN  = 16'h0000;
        DP   = 4'b0100;
        tick();
        chk_scan(e, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'h0);
        LOAD = 1'b0;
        while (e < 40) begin
            tick();
            chk_scan(e, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0100);
        end

        // Blanking off: every zero digit now lit.
        BLANK_LZ = 1'b0;
        while (e < 46) begin
            tick();
            chk_scan(e, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0100);
        end

        // LOAD at edge 47, cycle 2 of digit 1.
        LOAD = 1'b1;
        BIN  = 16'h0050;
        DP   = 4'h0;
        tick();
        chk_scan(e, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0100);
        LOAD = 1'b0;
        BIN  = 16'hFFFF;
        DP   = 4'hF;
        while (e < 75) begin
            tick();
            chk_scan(e, {7'h40, 7'h40, 7'h12, 7'h40}, 4'h0);
        end

        // Edge 75 is the guard after digit 2; reset there.
        #2;
        RST_N = 1'b0;
        #1;
        chk_off("guard_rst");
        tick();
        chk_off("guard_rst_hold0");
        tick();
        chk_off("guard_rst_hold1");

        // Restart at digit 0 with the cleared shadow; first FRAME at edge 21.
        RST_N = 1'b1;
        e     = 0;
        while (e < 21) begin
            tick();
            chk_scan(e, {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
